// File: rtl/branch_rs_pkg.sv
// Shared CPU bus widths, branch opcodes and the reservation-station entry layout
// used by the branch reservation station and its helpers.
package branch_rs_pkg;

   localparam int OP_BUS       = 6;
   localparam int DATA_BUS     = 32;
   localparam int TAG_BUS      = 4;
   localparam int ADDR_BUS     = 32;
   localparam int BranchRSSize = 8;

   localparam logic VALID   = 1'b1;
   localparam logic INVALID = 1'b0;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam logic [DATA_BUS-1:0] NULL_DATA = '0;

   localparam logic [OP_BUS-1:0] OP_BEQ  = 6'd1;
   localparam logic [OP_BUS-1:0] OP_BNE  = 6'd2;
   localparam logic [OP_BUS-1:0] OP_BLT  = 6'd3;
   localparam logic [OP_BUS-1:0] OP_BGE  = 6'd4;
   localparam logic [OP_BUS-1:0] OP_BLTU = 6'd5;
   localparam logic [OP_BUS-1:0] OP_BGEU = 6'd6;
   localparam logic [OP_BUS-1:0] OP_JAL  = 6'd7;
   localparam logic [OP_BUS-1:0] OP_JALR = 6'd8;

   typedef struct packed {
      logic                busy;
      logic [OP_BUS-1:0]   op;
      logic [DATA_BUS-1:0] vj;
      logic [DATA_BUS-1:0] vk;
      logic                qj_busy;
      logic [TAG_BUS-1:0]  qj;
      logic                qk_busy;
      logic [TAG_BUS-1:0]  qk;
      logic [TAG_BUS-1:0]  dest;
      logic [DATA_BUS-1:0] imm;
      logic [ADDR_BUS-1:0] pc;
   } rs_entry_t;

   // Full-width tag compare gated by the broadcast valid.
   function automatic logic tag_hit(input logic cdb_valid,
                                    input logic [TAG_BUS-1:0] cdb_tag,
                                    input logic [TAG_BUS-1:0] wait_tag);
      return (cdb_valid == VALID) && (cdb_tag == wait_tag);
   endfunction

endpackage

// File: rtl/branch_rs_prio_enc.sv
// Lowest-index-first priority encoder, shared by the free-slot and ready-entry
// searches of the branch reservation station.
module rs_prio_enc #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         req,
   output logic                     found,
   output logic [$clog2(WIDTH)-1:0] idx
);

   localparam int IDX_W = $clog2(WIDTH);

   // Scan from the top down so the lowest set request is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/branch_rs.sv
// Branch/jump reservation station: holds dispatched branches until both operands
// are known, snoops two result buses, and issues the lowest ready entry per cycle.
module branch_rs
   import branch_rs_pkg::*;
#(
   parameter int RS_SIZE = BranchRSSize
) (
   input  logic                clk_in,
   input  logic                rst_n,
   input  logic                rdy_in,

   input  logic                Dispatch_enable,
   input  logic [OP_BUS-1:0]   Dispatch_op,
   input  logic [DATA_BUS-1:0] Dispatch_Vj,
   input  logic [DATA_BUS-1:0] Dispatch_Vk,
   input  logic                Dispatch_Qj_busy,
   input  logic                Dispatch_Qk_busy,
   input  logic [TAG_BUS-1:0]  Dispatch_Qj,
   input  logic [TAG_BUS-1:0]  Dispatch_Qk,
   input  logic [TAG_BUS-1:0]  Dispatch_dest_rob,
   input  logic [DATA_BUS-1:0] Dispatch_imm,
   input  logic [ADDR_BUS-1:0] Dispatch_pc,
   output logic                RS_full,

   input  logic                CDB0_valid,
   input  logic [TAG_BUS-1:0]  CDB0_tag,
   input  logic [DATA_BUS-1:0] CDB0_data,
   input  logic                CDB1_valid,
   input  logic [TAG_BUS-1:0]  CDB1_tag,
   input  logic [DATA_BUS-1:0] CDB1_data,

   input  logic                ROB_clear,

   output logic                BranchRS_enable,
   output logic [OP_BUS-1:0]   BranchRS_op,
   output logic [DATA_BUS-1:0] BranchRS_reg1,
   output logic [DATA_BUS-1:0] BranchRS_reg2,
   output logic [TAG_BUS-1:0]  BranchRS_dest_rob,
   output logic [DATA_BUS-1:0] BranchRS_imm,
   output logic [ADDR_BUS-1:0] BranchRS_pc
);

   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = IDX_W + 1;

   rs_entry_t          entries [RS_SIZE];
   rs_entry_t          new_entry;
   logic [CNT_W-1:0]   busy_count;
   logic [RS_SIZE-1:0] free_vec;
   logic [RS_SIZE-1:0] ready_vec;
   logic               free_found;
   logic               ready_found;
   logic [IDX_W-1:0]   free_idx;
   logic [IDX_W-1:0]   ready_idx;
   logic               do_dispatch;

   always_comb begin
      free_vec  = '0;
      ready_vec = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         free_vec[i]  = ~entries[i].busy;
         ready_vec[i] = entries[i].busy & ~entries[i].qj_busy & ~entries[i].qk_busy;
      end
   end

   rs_prio_enc #(.WIDTH(RS_SIZE)) u_free_enc (
      .req   (free_vec),
      .found (free_found),
      .idx   (free_idx)
   );

   rs_prio_enc #(.WIDTH(RS_SIZE)) u_ready_enc (
      .req   (ready_vec),
      .found (ready_found),
      .idx   (ready_idx)
   );

   assign RS_full     = (busy_count == CNT_W'(RS_SIZE));
   assign do_dispatch = Dispatch_enable && !RS_full && free_found;

   // Build the incoming entry, forwarding any operand broadcast in this same cycle.
   always_comb begin
      new_entry         = '0;
      new_entry.busy    = 1'b1;
      new_entry.op      = Dispatch_op;
      new_entry.vj      = Dispatch_Vj;
      new_entry.vk      = Dispatch_Vk;
      new_entry.qj_busy = Dispatch_Qj_busy;
      new_entry.qj      = Dispatch_Qj;
      new_entry.qk_busy = Dispatch_Qk_busy;
      new_entry.qk      = Dispatch_Qk;
      new_entry.dest    = Dispatch_dest_rob;
      new_entry.imm     = Dispatch_imm;
      new_entry.pc      = Dispatch_pc;
      if (Dispatch_Qj_busy) begin
         if (tag_hit(CDB0_valid, CDB0_tag, Dispatch_Qj)) begin
            new_entry.vj      = CDB0_data;
            new_entry.qj_busy = 1'b0;
         end else if (tag_hit(CDB1_valid, CDB1_tag, Dispatch_Qj)) begin
            new_entry.vj      = CDB1_data;
            new_entry.qj_busy = 1'b0;
         end
      end
      if (Dispatch_Qk_busy) begin
         if (tag_hit(CDB0_valid, CDB0_tag, Dispatch_Qk)) begin
            new_entry.vk      = CDB0_data;
            new_entry.qk_busy = 1'b0;
         end else if (tag_hit(CDB1_valid, CDB1_tag, Dispatch_Qk)) begin
            new_entry.vk      = CDB1_data;
            new_entry.qk_busy = 1'b0;
         end
      end
   end

   // Flush beats everything, even a stalled pipeline; otherwise snoop, issue and
   // dispatch all act on the same edge against the registered entry state.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries[i] <= '0;
         end
         busy_count        <= '0;
         BranchRS_enable   <= DISABLE;
         BranchRS_op       <= '0;
         BranchRS_reg1     <= NULL_DATA;
         BranchRS_reg2     <= NULL_DATA;
         BranchRS_dest_rob <= '0;
         BranchRS_imm      <= NULL_DATA;
         BranchRS_pc       <= '0;
      end else if (ROB_clear) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            entries[i].busy <= 1'b0;
         end
         busy_count        <= '0;
         BranchRS_enable   <= DISABLE;
         BranchRS_op       <= '0;
         BranchRS_reg1     <= NULL_DATA;
         BranchRS_reg2     <= NULL_DATA;
         BranchRS_dest_rob <= '0;
         BranchRS_imm      <= NULL_DATA;
         BranchRS_pc       <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (entries[i].busy && entries[i].qj_busy) begin
               if (tag_hit(CDB0_valid, CDB0_tag, entries[i].qj)) begin
                  entries[i].vj      <= CDB0_data;
                  entries[i].qj_busy <= 1'b0;
               end else if (tag_hit(CDB1_valid, CDB1_tag, entries[i].qj)) begin
                  entries[i].vj      <= CDB1_data;
                  entries[i].qj_busy <= 1'b0;
               end
            end
            if (entries[i].busy && entries[i].qk_busy) begin
               if (tag_hit(CDB0_valid, CDB0_tag, entries[i].qk)) begin
                  entries[i].vk      <= CDB0_data;
                  entries[i].qk_busy <= 1'b0;
               end else if (tag_hit(CDB1_valid, CDB1_tag, entries[i].qk)) begin
                  entries[i].vk      <= CDB1_data;
                  entries[i].qk_busy <= 1'b0;
               end
            end
         end

         if (ready_found) begin
            entries[ready_idx].busy <= 1'b0;
            BranchRS_enable         <= ENABLE;
            BranchRS_op             <= entries[ready_idx].op;
            BranchRS_reg1           <= entries[ready_idx].vj;
            BranchRS_reg2           <= entries[ready_idx].vk;
            BranchRS_dest_rob       <= entries[ready_idx].dest;
            BranchRS_imm            <= entries[ready_idx].imm;
            BranchRS_pc             <= entries[ready_idx].pc;
         end else begin
            BranchRS_enable         <= DISABLE;
            BranchRS_op             <= '0;
            BranchRS_reg1           <= NULL_DATA;
            BranchRS_reg2           <= NULL_DATA;
            BranchRS_dest_rob       <= '0;
            BranchRS_imm            <= NULL_DATA;
            BranchRS_pc             <= '0;
         end

         if (do_dispatch) begin
            entries[free_idx] <= new_entry;
         end

         case ({do_dispatch, ready_found})
            2'b10:   busy_count <= busy_count + CNT_W'(1);
            2'b01:   busy_count <= busy_count - CNT_W'(1);
            default: busy_count <= busy_count;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: stimulus pushes expected issues (with the cycle
// they must appear in), a negedge monitor pops and compares every issue.
module tb_branch_rs;
   import branch_rs_pkg::*;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [3:0]  dest;
      logic [31:0] imm;
      logic [31:0] pc;
      int          cyc;
   } exp_t;

   logic        clk_in, rst_n, rdy_in;
   logic        Dispatch_enable;
   logic [5:0]  Dispatch_op;
   logic [31:0] Dispatch_Vj, Dispatch_Vk;
   logic        Dispatch_Qj_busy, Dispatch_Qk_busy;
   logic [3:0]  Dispatch_Qj, Dispatch_Qk, Dispatch_dest_rob;
   logic [31:0] Dispatch_imm, Dispatch_pc;
   logic        RS_full;
   logic        CDB0_valid, CDB1_valid;
   logic [3:0]  CDB0_tag, CDB1_tag;
   logic [31:0] CDB0_data, CDB1_data;
   logic        ROB_clear;
   logic        BranchRS_enable;
   logic [5:0]  BranchRS_op;
   logic [31:0] BranchRS_reg1, BranchRS_reg2, BranchRS_imm, BranchRS_pc;
   logic [3:0]  BranchRS_dest_rob;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;

   branch_rs #(.RS_SIZE(8)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .rdy_in(rdy_in),
      .Dispatch_enable(Dispatch_enable), .Dispatch_op(Dispatch_op),
      .Dispatch_Vj(Dispatch_Vj), .Dispatch_Vk(Dispatch_Vk),
      .Dispatch_Qj_busy(Dispatch_Qj_busy), .Dispatch_Qk_busy(Dispatch_Qk_busy),
      .Dispatch_Qj(Dispatch_Qj), .Dispatch_Qk(Dispatch_Qk),
      .Dispatch_dest_rob(Dispatch_dest_rob), .Dispatch_imm(Dispatch_imm),
      .Dispatch_pc(Dispatch_pc), .RS_full(RS_full),
      .CDB0_valid(CDB0_valid), .CDB0_tag(CDB0_tag), .CDB0_data(CDB0_data),
      .CDB1_valid(CDB1_valid), .CDB1_tag(CDB1_tag), .CDB1_data(CDB1_data),
      .ROB_clear(ROB_clear),
      .BranchRS_enable(BranchRS_enable), .BranchRS_op(BranchRS_op),
      .BranchRS_reg1(BranchRS_reg1), .BranchRS_reg2(BranchRS_reg2),
      .BranchRS_dest_rob(BranchRS_dest_rob), .BranchRS_imm(BranchRS_imm),
      .BranchRS_pc(BranchRS_pc)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(posedge clk_in) cycle <= cycle + 1;

   // Monitor: every issue must match the head of the scoreboard, including its cycle.
   always @(negedge clk_in) begin
      if (rst_n) begin
         vectors++;
         if (BranchRS_enable) begin
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL unexpected_issue: got op=%0d pc=%h at cycle %0d, required no issue",
                        BranchRS_op, BranchRS_pc, cycle);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (BranchRS_op !== e.op || BranchRS_reg1 !== e.r1 || BranchRS_reg2 !== e.r2 ||
                   BranchRS_dest_rob !== e.dest || BranchRS_imm !== e.imm ||
                   BranchRS_pc !== e.pc || cycle != e.cyc) begin
                  miscompares++;
                  $display("[TB] FAIL issue: got op=%0d r1=%h r2=%h dest=%0d imm=%h pc=%h cyc=%0d, required op=%0d r1=%h r2=%h dest=%0d imm=%h pc=%h cyc=%0d",
                           BranchRS_op, BranchRS_reg1, BranchRS_reg2, BranchRS_dest_rob,
                           BranchRS_imm, BranchRS_pc, cycle, e.op, e.r1, e.r2, e.dest,
                           e.imm, e.pc, e.cyc);
               end
            end
         end else if (BranchRS_op !== '0 || BranchRS_reg1 !== '0 || BranchRS_reg2 !== '0 ||
                      BranchRS_dest_rob !== '0 || BranchRS_imm !== '0 || BranchRS_pc !== '0) begin
            miscompares++;
            $display("[TB] FAIL idle_zero: got op=%0d r1=%h r2=%h pc=%h at cycle %0d, required all zero",
                     BranchRS_op, BranchRS_reg1, BranchRS_reg2, BranchRS_pc, cycle);
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic expectIssue(input logic [5:0] op, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [3:0] dest,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input int cyc);
      exp_t e;
      e.op = op; e.r1 = r1; e.r2 = r2; e.dest = dest;
      e.imm = imm; e.pc = pc; e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   // One-cycle dispatch; CDB / ROB_clear drive is left to the caller.
   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] vj,
                                input logic [31:0] vk, input logic qj_busy,
                                input logic [3:0] qj, input logic qk_busy,
                                input logic [3:0] qk, input logic [3:0] dest,
                                input logic [31:0] imm, input logic [31:0] pc);
      Dispatch_op = op;   Dispatch_Vj = vj;   Dispatch_Vk = vk;
      Dispatch_Qj_busy = qj_busy;  Dispatch_Qj = qj;
      Dispatch_Qk_busy = qk_busy;  Dispatch_Qk = qk;
      Dispatch_dest_rob = dest;    Dispatch_imm = imm;   Dispatch_pc = pc;
      Dispatch_enable = 1'b1;
      tick();
      Dispatch_enable = 1'b0;
   endtask

   initial begin
      int c;
      int b;
      rst_n = 1'b0; rdy_in = 1'b1; ROB_clear = 1'b0;
      Dispatch_enable = 1'b0; Dispatch_op = '0; Dispatch_Vj = '0; Dispatch_Vk = '0;
      Dispatch_Qj_busy = 1'b0; Dispatch_Qk_busy = 1'b0; Dispatch_Qj = '0; Dispatch_Qk = '0;
      Dispatch_dest_rob = '0; Dispatch_imm = '0; Dispatch_pc = '0;
      CDB0_valid = 1'b0; CDB0_tag = '0; CDB0_data = '0;
      CDB1_valid = 1'b0; CDB1_tag = '0; CDB1_data = '0;

      #12;
      checkOutput("reset_enable", {31'b0, BranchRS_enable}, 32'd0);
      checkOutput("reset_full", {31'b0, RS_full}, 32'd0);
      checkOutput("reset_pc", BranchRS_pc, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Direct issue: ready at dispatch, issues two edges after the drive cycle.
      c = cycle;
      expectIssue(OP_BEQ, 32'd5, 32'd5, 4'd3, 32'd8, 32'h100, c + 2);
      applyStimulus(OP_BEQ, 32'd5, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'd8, 32'h100);
      tick();
      tick();
      checkOutput("s1_enable_drop", {31'b0, BranchRS_enable}, 32'd0);

      // Snoop capture on CDB1 two cycles after dispatch.
      applyStimulus(OP_BLT, 32'd0, 32'h33, 1'b1, 4'd7, 1'b0, 4'd0, 4'd4, 32'h10, 32'h200);
      tick();
      CDB1_valid = 1'b1; CDB1_tag = 4'd7; CDB1_data = 32'hFFFF_FFFF;
      b = cycle;
      expectIssue(OP_BLT, 32'hFFFF_FFFF, 32'h33, 4'd4, 32'h10, 32'h200, b + 2);
      tick();
      CDB1_valid = 1'b0;
      tick(); tick();

      // Dispatch-time forwarding from CDB0.
      CDB0_valid = 1'b1; CDB0_tag = 4'd2; CDB0_data = 32'h2000;
      c = cycle;
      expectIssue(OP_JALR, 32'h2000, 32'h0, 4'd5, 32'h4, 32'h300, c + 2);
      applyStimulus(OP_JALR, 32'hDEAD, 32'h0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5, 32'h4, 32'h300);
      CDB0_valid = 1'b0;
      tick(); tick();

      // Both CDBs carry the awaited Qk tag: CDB0 wins.
      applyStimulus(OP_BNE, 32'h1, 32'h0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6, 32'h20, 32'h340);
      CDB0_valid = 1'b1; CDB0_tag = 4'd4; CDB0_data = 32'hAAAA;
      CDB1_valid = 1'b1; CDB1_tag = 4'd4; CDB1_data = 32'hBBBB;
      b = cycle;
      expectIssue(OP_BNE, 32'h1, 32'hAAAA, 4'd6, 32'h20, 32'h340, b + 2);
      tick();
      CDB0_valid = 1'b0; CDB1_valid = 1'b0;
      tick(); tick();

      // Fill all eight entries on tag 9, drop a ninth, then drain in index order.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(OP_BGE, 32'd0, 32'h100 + i, 1'b1, 4'd9, 1'b0, 4'd0,
                       4'(i), 32'(i), 32'h400 + 4 * i);
      end
      checkOutput("full_set", {31'b0, RS_full}, 32'd1);
      applyStimulus(OP_BGE, 32'd0, 32'hEEE, 1'b1, 4'd9, 1'b0, 4'd0, 4'd15, 32'hEE, 32'h4F0);
      checkOutput("full_hold", {31'b0, RS_full}, 32'd1);
      CDB0_valid = 1'b1; CDB0_tag = 4'd9; CDB0_data = 32'h99;
      b = cycle;
      for (int i = 0; i < 8; i++) begin
         expectIssue(OP_BGE, 32'h99, 32'h100 + i, 4'(i), 32'(i), 32'h400 + 4 * i, b + 2 + i);
      end
      tick();
      CDB0_valid = 1'b0;
      tick();
      checkOutput("full_drop", {31'b0, RS_full}, 32'd0);
      repeat (9) tick();

      // Stall: rdy_in low for three edges delays the issue by three cycles.
      c = cycle;
      expectIssue(OP_BGEU, 32'h7, 32'h8, 4'd2, 32'h30, 32'h500, c + 5);
      applyStimulus(OP_BGEU, 32'h7, 32'h8, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'h30, 32'h500);
      rdy_in = 1'b0;
      tick(); tick(); tick();
      rdy_in = 1'b1;
      tick(); tick();

      // Flush with three ready entries and a concurrent dispatch.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_BEQ, 32'd0, 32'd1, 1'b1, 4'd11, 1'b0, 4'd0,
                       4'(8 + i), 32'd0, 32'h600 + 4 * i);
      end
      CDB1_valid = 1'b1; CDB1_tag = 4'd11; CDB1_data = 32'h11;
      tick();
      CDB1_valid = 1'b0;
      ROB_clear = 1'b1;
      applyStimulus(OP_BNE, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12, 32'd0, 32'h700);
      ROB_clear = 1'b0;
      checkOutput("flush_enable", {31'b0, BranchRS_enable}, 32'd0);
      checkOutput("flush_count", 32'(dut.busy_count), 32'd0);
      checkOutput("flush_full", {31'b0, RS_full}, 32'd0);
      repeat (4) tick();

      // Asynchronous reset while an issue is on the outputs; the next entry is lost.
      applyStimulus(OP_BLTU, 32'h5, 32'h6, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'h40, 32'h800);
      applyStimulus(OP_BNE, 32'h9, 32'h9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 32'h44, 32'h804);
      checkOutput("rst_pre_enable", {31'b0, BranchRS_enable}, 32'd1);
      checkOutput("rst_pre_pc", BranchRS_pc, 32'h800);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_enable", {31'b0, BranchRS_enable}, 32'd0);
      checkOutput("rst_async_pc", BranchRS_pc, 32'd0);
      checkOutput("rst_async_reg1", BranchRS_reg1, 32'd0);
      checkOutput("rst_async_full", {31'b0, RS_full}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      repeat (5) tick();

      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
